ss_mem_sequencer: RTL

- Sequences the single-cycle RV32 core against one shared single-port synchronous RAM with 1-cycle read latency.
- Splits every instruction into fetch, execute and optional load-wait phases, and holds the fetched instruction and load data stable for the core.
- Issues a one-cycle commit enable that gates the core's PC and register-file updates.
- Arbitrates the RAM between the core and an external loader/debug port, with alternating priority at instruction boundaries.

---
 rtl/ss_mem_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ss_mem_sequencer.sv
// ss_mem_sequencer
//   Sequences a single-cycle RV32 core against one shared single-port
//   synchronous RAM (1-cycle read latency). Each instruction is split into
//   fetch / execute / optional load-wait phases. core_en is the one-cycle
//   commit pulse that gates PC and register-file updates. An external
//   loader/debug port shares the RAM, with priority alternating at
//   instruction boundaries.
//
// Ports
//   clk, rst                      clock (rising edge), sync active-low reset
//   core_pc/alu_result/write_data core byte addresses and store data
//   core_mem_write                core store indicator
//   core_instr, core_read_data    held instruction / load data
//   core_en                       commit pulse
//   mem_addr/re/we/wdata/rdata    RAM port (word address)
//   ext_req/we/addr/wdata         external request, held until ext_gnt
//   ext_gnt, ext_rvalid, ext_rdata external grant and read return
module ss_mem_sequencer #(
  parameter int          AW        = 12,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   core_pc,
  input  logic [31:0]   core_alu_result,
  input  logic [31:0]   core_write_data,
  input  logic          core_mem_write,
  output logic [31:0]   core_instr,
  output logic [31:0]   core_read_data,
  output logic          core_en,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [31:0]   ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [31:0]   ext_rdata
);

  typedef enum logic [2:0] {FETCH, FWAIT, EXEC, LWAIT, COMMIT, XWAIT} state_t;

  state_t      state;
  logic [31:0] instr_q;
  logic [31:0] rdata_q;
  logic        ext_prio;

  // Byte addresses map to words; low bits and bits above the RAM are dropped.
  logic [AW-1:0] pc_waddr, alu_waddr;
  assign pc_waddr  = core_pc[AW+1:2];
  assign alu_waddr = core_alu_result[AW+1:2];

  logic unused_bits;
  assign unused_bits = ^{core_pc[31:AW+2], core_pc[1:0],
                         core_alu_result[31:AW+2], core_alu_result[1:0]};

  logic is_load, ext_win;
  assign is_load = (instr_q[6:0] == 7'b0000011);
  assign ext_win = (state == FETCH) && ext_req && ext_prio;

  assign core_instr     = instr_q;
  assign core_read_data = rdata_q;

  // RAM strobes and pulses are decoded from the registered state so the RAM
  // sees the address in the same cycle the phase begins; everything is
  // forced low while reset is held.
  always_comb begin
    core_en    = 1'b0;
    mem_addr   = '0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    ext_gnt    = 1'b0;
    ext_rvalid = 1'b0;
    ext_rdata  = '0;
    if (rst) begin
      unique case (state)
        FETCH: begin
          if (ext_win) begin
            ext_gnt   = 1'b1;
            mem_addr  = ext_addr;
            mem_we    = ext_we;
            mem_re    = !ext_we;
            mem_wdata = ext_wdata;
          end else begin
            mem_re   = 1'b1;
            mem_addr = pc_waddr;
          end
        end
        EXEC: begin
          if (is_load) begin
            mem_re   = 1'b1;
            mem_addr = alu_waddr;
          end else begin
            core_en = 1'b1;
            if (core_mem_write) begin
              mem_we    = 1'b1;
              mem_addr  = alu_waddr;
              mem_wdata = core_write_data;
            end
          end
        end
        COMMIT: core_en = 1'b1;
        XWAIT: begin
          ext_rvalid = 1'b1;
          ext_rdata  = mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FETCH;
      instr_q  <= NOP_INSTR;
      rdata_q  <= '0;
      ext_prio <= 1'b1;
    end else begin
      unique case (state)
        FETCH: begin
          if (ext_win) begin
            // Ext write completes in the grant cycle; a read needs one more.
            ext_prio <= 1'b0;
            state    <= ext_we ? FETCH : XWAIT;
          end else begin
            ext_prio <= 1'b1;
            state    <= FWAIT;
          end
        end
        FWAIT: begin
          instr_q <= mem_rdata;
          state   <= EXEC;
        end
        EXEC:   state <= is_load ? LWAIT : FETCH;
        LWAIT: begin
          rdata_q <= mem_rdata;
          state   <= COMMIT;
        end
        COMMIT: state <= FETCH;
        XWAIT:  state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

endmodule
